// File: rtl/mat_ctrl_pkg.sv
// Shared types and defaults for the matrix-multiplier sequencing controller.
package mat_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StPreload,
        StLoad,
        StCalc,
        StNextRow,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DefRows    = 28;
    localparam int unsigned DefCols    = 28;
    localparam int unsigned DefPreRows = 2;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_seq_ctrl_if.sv
// Host/datapath handshake bundle of the sequencing controller.
interface mat_seq_ctrl_if #(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned SH_W  = 5
);
    logic             start_in;
    logic             keep_A;
    logic             abort;
    logic             stall;
    logic             load_A_done;
    logic             load_done;
    logic             pready;
    logic             busy;
    logic             load_A_en;
    logic             load_en;
    logic             ALU_en;
    logic             row_finish;
    logic             done;
    logic [CNT_W-1:0] row_count;
    logic [CNT_W-1:0] pass_count;
    logic [SH_W-1:0]  col_count;

    modport master (
        output start_in, keep_A, abort, stall, load_A_done, load_done,
        input  pready, busy, load_A_en, load_en, ALU_en, row_finish, done,
        input  row_count, pass_count, col_count
    );

    modport slave (
        input  start_in, keep_A, abort, stall, load_A_done, load_done,
        output pready, busy, load_A_en, load_en, ALU_en, row_finish, done,
        output row_count, pass_count, col_count
    );
endinterface

// File: rtl/mat_pass_counter.sv
// Stall-aware shift-column counter and completed-pass counter.
module mat_pass_counter #(
    parameter int unsigned COLS  = 28,
    parameter int unsigned SH_W  = 5,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [SH_W-1:0]  col_count,
    output logic [CNT_W-1:0] pass_count,
    output logic             row_finish
);
    localparam logic [SH_W-1:0] ColLast = SH_W'(COLS - 1);

    logic [SH_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0] pass_q, pass_d;

    assign row_finish = en && (col_q == ColLast);

    always_comb begin
        col_d  = col_q;
        pass_d = pass_q;
        if (clr) begin
            col_d  = '0;
            pass_d = '0;
        end else if (en) begin
            col_d = row_finish ? '0 : col_q + 1'b1;
            if (row_finish) begin
                pass_d = pass_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            pass_q <= '0;
        end else begin
            col_q  <= col_d;
            pass_q <= pass_d;
        end
    end

    assign col_count  = col_q;
    assign pass_count = pass_q;
endmodule

// File: rtl/mat_seq_ctrl.sv
// Job sequencer: A load, row preload, per-row shift passes and drain of the operand pipeline.
module mat_seq_ctrl
    import mat_ctrl_pkg::*;
#(
    parameter int unsigned ROWS     = DefRows,
    parameter int unsigned COLS     = DefCols,
    parameter int unsigned PRE_ROWS = DefPreRows,
    parameter int unsigned CNT_W    = cnt_width(ROWS + 1),
    parameter int unsigned SH_W     = cnt_width(COLS)
) (
    input logic          clk,
    input logic          rst,
    mat_seq_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] RowsC    = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] PreLast  = CNT_W'(PRE_ROWS - 1);
    localparam logic [CNT_W-1:0] PassLast = CNT_W'(ROWS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] row_q, pass_count;
    logic [SH_W-1:0]  col_count;
    logic             alu_en, row_finish, clr, load_ok;

    assign alu_en  = (state_q inside {StCalc, StDrain}) && !bus.stall;
    // Counters clear on an accepted start, or on abort of a running job.
    assign clr     = (state_q == StIdle) ? bus.start_in : bus.abort;
    assign load_ok = bus.load_done && (state_q inside {StPreload, StLoad});

    mat_pass_counter #(
        .COLS  (COLS),
        .SH_W  (SH_W),
        .CNT_W (CNT_W)
    ) u_pass (
        .clk        (clk),
        .rst        (rst),
        .en         (alu_en),
        .clr        (clr),
        .col_count  (col_count),
        .pass_count (pass_count),
        .row_finish (row_finish)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                row_q <= '0;
            end else if (load_ok) begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pready     = 1'b0;
        bus.load_A_en  = 1'b0;
        bus.load_en    = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.pready = 1'b1;
                if (bus.start_in) state_d = bus.keep_A ? StPreload : StLoadA;
            end
            StLoadA: begin
                bus.pready    = 1'b1;
                bus.load_A_en = 1'b1;
                if (bus.load_A_done) state_d = StPreload;
            end
            StPreload: begin
                bus.pready  = 1'b1;
                bus.load_en = 1'b1;
                if (bus.load_done && row_q == PreLast) state_d = StCalc;
            end
            StLoad: begin
                bus.pready  = 1'b1;
                bus.load_en = 1'b1;
                if (bus.load_done) state_d = StCalc;
            end
            StCalc: begin
                if (row_finish) state_d = StNextRow;
            end
            StNextRow: begin
                // With a single-row pipeline every pass follows a load, so no drain is needed.
                if (row_q < RowsC)      state_d = StLoad;
                else if (PRE_ROWS == 1) state_d = StDone;
                else                    state_d = StDrain;
            end
            StDrain: begin
                if (row_finish && pass_count == PassLast) state_d = StDone;
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (bus.abort && state_q != StIdle) state_d = StIdle;
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.ALU_en     = alu_en;
    assign bus.row_finish = row_finish;
    assign bus.row_count  = row_q;
    assign bus.pass_count = pass_count;
    assign bus.col_count  = col_count;
endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Self-checking bench: vector tables, directed job scenarios and a randomized model comparison.
module tb_mat_seq_ctrl;
    import mat_ctrl_pkg::*;

    localparam int unsigned RA = 4, CA = 3, PA = 2;
    localparam int unsigned CWA = cnt_width(RA + 1), SWA = cnt_width(CA);
    localparam int unsigned RB = 1, CB = 2, PB = 1;
    localparam int unsigned CWB = cnt_width(RB + 1), SWB = cnt_width(CB);

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    mat_seq_ctrl_if #(.CNT_W(CWA), .SH_W(SWA)) ba ();
    mat_seq_ctrl_if #(.CNT_W(CWB), .SH_W(SWB)) bb ();

    mat_seq_ctrl #(
        .ROWS(RA), .COLS(CA), .PRE_ROWS(PA), .CNT_W(CWA), .SH_W(SWA)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(ba));

    mat_seq_ctrl #(
        .ROWS(RB), .COLS(CB), .PRE_ROWS(PB), .CNT_W(CWB), .SH_W(SWB)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(bb));

    // Inputs {start_in, keep_A, abort, stall, load_A_done, load_done};
    // flags {pready, busy, load_A_en, load_en, ALU_en, row_finish, done}.
    typedef struct {
        logic [5:0] in;
        logic [6:0] fl;
        int         rc, pc, cc;
    } vec_t;

    typedef struct {
        bit active, a_ok, gap, fin;
        int loads, passes, col;
    } m_t;

    int checks = 0;
    int errors = 0;
    vec_t tab_a[22];
    vec_t tab_b[7];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int pack_exp(input logic [6:0] fl, input int rc, input int pc, input int cc);
        return int'({fl, 8'(rc), 8'(pc), 8'(cc)});
    endfunction

    function automatic int obs(input bit b);
        if (!b) return int'({ba.pready, ba.busy, ba.load_A_en, ba.load_en, ba.ALU_en,
                             ba.row_finish, ba.done, 8'(ba.row_count), 8'(ba.pass_count),
                             8'(ba.col_count)});
        return int'({bb.pready, bb.busy, bb.load_A_en, bb.load_en, bb.ALU_en, bb.row_finish,
                     bb.done, 8'(bb.row_count), 8'(bb.pass_count), 8'(bb.col_count)});
    endfunction

    task automatic drive(input bit b, input logic [5:0] v);
        if (!b) {ba.start_in, ba.keep_A, ba.abort, ba.stall, ba.load_A_done, ba.load_done} = v;
        else    {bb.start_in, bb.keep_A, bb.abort, bb.stall, bb.load_A_done, bb.load_done} = v;
    endtask

    task automatic apply_vec(input bit b, input vec_t e, input string nm);
        @(negedge clk);
        drive(b, e.in);
        #1;
        check(nm, obs(b), pack_exp(e.fl, e.rc, e.pc, e.cc));
    endtask

    // Reference: the pass p (0-based) needs min(R, P+p) rows loaded; passes with P+p > R drain.
    function automatic int model_out(input m_t m, input int r, input int c, input int p,
                                     input logic [5:0] in);
        logic [6:0] fl;
        int need;
        need = (p + m.passes < r) ? p + m.passes : r;
        if (!m.active)          fl = 7'b1000000;
        else if (m.fin)         fl = 7'b0100001;
        else if (m.gap)         fl = 7'b0100000;
        else if (!m.a_ok)       fl = 7'b1110000;
        else if (m.loads < need) fl = 7'b1101000;
        else begin
            fl    = 7'b0100000;
            fl[2] = !in[2];
            fl[1] = !in[2] && (m.col == c - 1);
        end
        return pack_exp(fl, m.loads, m.passes, m.col);
    endfunction

    function automatic m_t model_next(input m_t m, input int r, input int c, input int p,
                                      input logic [5:0] in);
        m_t n;
        int need;
        n    = m;
        need = (p + m.passes < r) ? p + m.passes : r;
        if (!m.active) begin
            if (in[5]) n = '{active: 1'b1, a_ok: in[4], gap: 1'b0, fin: 1'b0,
                             loads: 0, passes: 0, col: 0};
        end else if (in[3]) begin
            n = '{default: 0};
        end else if (m.fin) begin
            n.active = 1'b0;
            n.fin    = 1'b0;
        end else if (m.gap) begin
            n.gap = 1'b0;
            if (m.passes == r) n.fin = 1'b1;
        end else if (!m.a_ok) begin
            if (in[1]) n.a_ok = 1'b1;
        end else if (m.loads < need) begin
            if (in[0]) n.loads = m.loads + 1;
        end else if (!in[2]) begin
            if (m.col == c - 1) begin
                n.col    = 0;
                n.passes = m.passes + 1;
                if (p + m.passes <= r)   n.gap = 1'b1;
                else if (m.passes + 1 == r) n.fin = 1'b1;
            end else begin
                n.col = m.col + 1;
            end
        end
        return n;
    endfunction

    // Runs one job on dut_a; loaders answer 2 cycles after their enable rises or after last pulse.
    task automatic run_job(input bit keep, input bit stall5, input bit spur,
                           output int loads, output int alu, output int rfs,
                           output int first_rf, output int last_rf, output int done_cyc,
                           output int ndone, output int stall_bad, output logic [1:0] c1);
        int wl, wa, stall_left;
        bit stalled, fin;
        logic [5:0] v;
        loads = 0; alu = 0; rfs = 0; ndone = 0; stall_bad = 0;
        first_rf = -1; last_rf = -1; done_cyc = -1; c1 = '0;
        wl = 0; wa = 0; stall_left = 0; stalled = 1'b0; fin = 1'b0;
        @(negedge clk);
        drive(1'b0, {1'b1, keep, 4'b0000});
        #1;
        for (int t = 1; t <= 200 && !fin; t++) begin
            @(negedge clk);
            v = '0;
            if (ba.load_A_en) begin
                wa++;
                if (wa == 3) begin v[1] = 1'b1; wa = 0; end
            end else wa = 0;
            if (ba.load_en) begin
                wl++;
                if (wl == 3) begin v[0] = 1'b1; wl = 0; end
            end else wl = 0;
            if (stall5 && !stalled && ba.busy && !ba.pready && ba.pass_count == 0 &&
                ba.col_count == 1) begin
                stall_left = 5;
                stalled    = 1'b1;
            end
            if (stall_left > 0) v[2] = 1'b1;
            if (spur && ba.busy && !ba.load_en) begin
                if (ba.load_A_en) v[0] = v[1];
                else begin
                    v[0] = 1'($urandom % 2);
                    v[5] = 1'($urandom % 2);
                    v[4] = 1'($urandom % 2);
                end
            end
            drive(1'b0, v);
            #1;
            if (t == 1) c1 = {ba.load_A_en, ba.load_en};
            if (ba.load_en && ba.load_done) loads++;
            if (ba.ALU_en) alu++;
            if (ba.row_finish) begin
                rfs++;
                if (first_rf < 0) first_rf = t;
                last_rf = t;
            end
            if (stall_left > 0) begin
                if (ba.ALU_en || ba.col_count != 1) stall_bad++;
                stall_left--;
            end
            if (ba.done) begin
                ndone++;
                done_cyc = t;
            end
            if (!ba.busy) fin = 1'b1;
        end
        check("job_terminates", int'(fin), 1);
        drive(1'b0, '0);
    endtask

    initial begin
        int ld, alu, rfs, frf, lrf, dc, nd, sb;
        logic [1:0] c1;
        bit found;
        logic [5:0] va, vb;
        m_t ma, mb;

        tab_a[0]  = '{6'b110000, 7'b1000000, 0, 0, 0};
        tab_a[1]  = '{6'b000001, 7'b1101000, 0, 0, 0};
        tab_a[2]  = '{6'b000001, 7'b1101000, 1, 0, 0};
        tab_a[3]  = '{6'b000000, 7'b0100100, 2, 0, 0};
        tab_a[4]  = '{6'b000000, 7'b0100100, 2, 0, 1};
        tab_a[5]  = '{6'b000000, 7'b0100110, 2, 0, 2};
        tab_a[6]  = '{6'b000000, 7'b0100000, 2, 1, 0};
        tab_a[7]  = '{6'b000001, 7'b1101000, 2, 1, 0};
        tab_a[8]  = '{6'b000000, 7'b0100100, 3, 1, 0};
        tab_a[9]  = '{6'b000000, 7'b0100100, 3, 1, 1};
        tab_a[10] = '{6'b000000, 7'b0100110, 3, 1, 2};
        tab_a[11] = '{6'b000000, 7'b0100000, 3, 2, 0};
        tab_a[12] = '{6'b000001, 7'b1101000, 3, 2, 0};
        tab_a[13] = '{6'b000000, 7'b0100100, 4, 2, 0};
        tab_a[14] = '{6'b000000, 7'b0100100, 4, 2, 1};
        tab_a[15] = '{6'b000000, 7'b0100110, 4, 2, 2};
        tab_a[16] = '{6'b000000, 7'b0100000, 4, 3, 0};
        tab_a[17] = '{6'b000000, 7'b0100100, 4, 3, 0};
        tab_a[18] = '{6'b000000, 7'b0100100, 4, 3, 1};
        tab_a[19] = '{6'b000000, 7'b0100110, 4, 3, 2};
        tab_a[20] = '{6'b000000, 7'b0100001, 4, 4, 0};
        tab_a[21] = '{6'b000000, 7'b1000000, 4, 4, 0};

        tab_b[0] = '{6'b110000, 7'b1000000, 0, 0, 0};
        tab_b[1] = '{6'b000001, 7'b1101000, 0, 0, 0};
        tab_b[2] = '{6'b000000, 7'b0100100, 1, 0, 0};
        tab_b[3] = '{6'b000000, 7'b0100110, 1, 0, 1};
        tab_b[4] = '{6'b000000, 7'b0100000, 1, 1, 0};
        tab_b[5] = '{6'b000000, 7'b0100001, 1, 1, 0};
        tab_b[6] = '{6'b000000, 7'b1000000, 1, 1, 0};

        drive(1'b0, '0);
        drive(1'b1, '0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #12;
        check("reset_a", obs(1'b0), pack_exp(7'b1000000, 0, 0, 0));
        check("reset_b", obs(1'b1), pack_exp(7'b1000000, 0, 0, 0));
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        for (int i = 0; i < 22; i++) apply_vec(1'b0, tab_a[i], $sformatf("tab_a[%0d]", i));
        for (int i = 0; i < 7; i++)  apply_vec(1'b1, tab_b[i], $sformatf("tab_b[%0d]", i));
        drive(1'b0, '0);
        drive(1'b1, '0);

        // Asynchronous reset in the middle of a pass on the single-row configuration.
        apply_vec(1'b1, '{6'b110000, 7'b1000000, 1, 1, 0}, "b2_start");
        apply_vec(1'b1, '{6'b000001, 7'b1101000, 0, 0, 0}, "b2_preload");
        apply_vec(1'b1, '{6'b000000, 7'b0100100, 1, 0, 0}, "b2_calc");
        #1 rst_b = 1'b0;
        #1 check("b_async_reset", obs(1'b1), pack_exp(7'b1000000, 0, 0, 0));
        @(negedge clk);
        rst_b = 1'b1;
        #1 check("b_after_reset", obs(1'b1), pack_exp(7'b1000000, 0, 0, 0));

        run_job(1'b0, 1'b0, 1'b0, ld, alu, rfs, frf, lrf, dc, nd, sb, c1);
        check("nom_loads", ld, 4);
        check("nom_alu", alu, 12);
        check("nom_rf", rfs, 4);
        check("nom_done_cnt", nd, 1);
        check("nom_done_cyc", dc, 31);
        check("nom_done_after_rf", dc - lrf, 1);
        check("nom_first_cyc", int'(c1), 2);
        check("nom_final", obs(1'b0), pack_exp(7'b1000000, 4, 4, 0));

        run_job(1'b1, 1'b0, 1'b0, ld, alu, rfs, frf, lrf, dc, nd, sb, c1);
        check("keep_first_cyc", int'(c1), 1);
        check("keep_loads", ld, 4);
        check("keep_alu", alu, 12);
        check("keep_first_rf", frf, 9);
        check("keep_done_cyc", dc, 28);

        run_job(1'b1, 1'b1, 1'b0, ld, alu, rfs, frf, lrf, dc, nd, sb, c1);
        check("stall_hold", sb, 0);
        check("stall_first_rf", frf, 14);
        check("stall_alu", alu, 12);
        check("stall_done_cyc", dc, 33);

        run_job(1'b0, 1'b0, 1'b1, ld, alu, rfs, frf, lrf, dc, nd, sb, c1);
        check("spur_loads", ld, 4);
        check("spur_rf", rfs, 4);
        check("spur_done_cyc", dc, 31);
        check("spur_final", obs(1'b0), pack_exp(7'b1000000, 4, 4, 0));

        // Abort in the second pass, then a clean job.
        @(negedge clk);
        drive(1'b0, 6'b110000);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            va = '0;
            if (ba.load_en) va[0] = 1'b1;
            if (ba.ALU_en && ba.pass_count == 1 && ba.col_count == 1) begin
                va[3] = 1'b1;
                found = 1'b1;
            end
            drive(1'b0, va);
        end
        check("abort_reached", int'(found), 1);
        @(negedge clk);
        drive(1'b0, '0);
        #1 check("abort_idle", obs(1'b0), pack_exp(7'b1000000, 0, 0, 0));
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            #1 check("abort_no_done", int'(ba.done), 0);
        end
        run_job(1'b1, 1'b0, 1'b0, ld, alu, rfs, frf, lrf, dc, nd, sb, c1);
        check("post_abort_alu", alu, 12);
        check("post_abort_done_cyc", dc, 28);

        // Randomized phase on both configurations against the reference model.
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        ma = '{default: 0};
        mb = '{default: 0};
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            va = {1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 64 == 0),
                  1'($urandom % 4 == 0), 1'($urandom % 3 == 0), 1'($urandom % 3 == 0)};
            vb = {1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 64 == 0),
                  1'($urandom % 4 == 0), 1'($urandom % 3 == 0), 1'($urandom % 3 == 0)};
            drive(1'b0, va);
            drive(1'b1, vb);
            #1;
            check($sformatf("rand_a[%0d]", n), obs(1'b0), model_out(ma, RA, CA, PA, va));
            check($sformatf("rand_b[%0d]", n), obs(1'b1), model_out(mb, RB, CB, PB, vb));
            ma = model_next(ma, RA, CA, PA, va);
            mb = model_next(mb, RB, CB, PB, vb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
